// File: rtl/instruction_decode_pkg.sv
// Shared decode constants: operation numbers, instruction classes and the
// 16-bit instruction word layout. Execution imports the same definitions.
package instruction_decode_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_ASR  = 6;
  localparam int unsigned OP_LSL  = 7;
  localparam int unsigned OP_LSR  = 8;
  localparam int unsigned OP_MOV  = 9;
  localparam int unsigned OP_ADDI = 10;
  localparam int unsigned OP_SUBI = 11;
  localparam int unsigned OP_ASRI = 12;
  localparam int unsigned OP_LSLI = 13;
  localparam int unsigned OP_LSRI = 14;
  localparam int unsigned OP_LDI  = 15;
  localparam int unsigned OP_LDB  = 16;
  localparam int unsigned OP_LDW  = 17;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;

  // Everything below the long flag; a latched prefix only needs these bits.
  typedef struct packed {
    logic [1:0] cls;    // [14:13]
    logic [3:0] opcode; // [12:9]
    logic [2:0] dest;   // [8:6]
    logic [2:0] src_1;  // [5:3]
    logic [2:0] src_2;  // [2:0]
  } instr_body_t;

  typedef struct packed {
    logic        long_flag; // [15]
    instr_body_t body;
  } instr_word_t;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } dec_state_e;

endpackage

// File: rtl/instruction_decode_decode_table.sv
// Combinational decode of class/opcode into an operation number, the raw
// immediates and the illegal flag.
module decode_table
  import instruction_decode_pkg::*;
#(
  parameter int OPNUM_W = 6
) (
  input  logic [1:0]         cls,
  input  logic [3:0]         opcode,
  input  logic [2:0]         src_1,
  input  logic [2:0]         src_2,
  input  logic               long_illegal,
  output logic [OPNUM_W-1:0] op,
  output logic [2:0]         imm_1,
  output logic [5:0]         imm_2,
  output logic               illegal
);

  always_comb begin
    op      = '0;
    illegal = 1'b0;
    imm_1   = src_2;
    imm_2   = {src_1, src_2};
    if (long_illegal) begin
      illegal = 1'b1;
    end else begin
      case (cls)
        // ALU opcodes 0..15 map one-to-one onto OP_NOP..OP_LDI
        CLS_ALU: op = OPNUM_W'(opcode);
        CLS_MEM: begin
          case (opcode)
            4'd0:    op = OPNUM_W'(OP_LDB);
            4'd1:    op = OPNUM_W'(OP_LDW);
            default: illegal = 1'b1;
          endcase
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: accepts 16-bit words from fetch, assembles two-word
// instructions and registers the decoded bundle for execution.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FIRST  | next accepted word starts an instruction
// ST_SECOND | long prefix latched; next accepted word completes it
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int OPNUM_W = 6,
  parameter bit LONG_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        instr_word,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [OPNUM_W-1:0] operationnumber,
  output logic [2:0]         destination,
  output logic [2:0]         source_1,
  output logic [2:0]         source_2,
  output logic [2:0]         unsigned_1,
  output logic [5:0]         unsigned_2,
  output logic [8:0]         unsigned_3,
  output logic               decode_valid,
  output logic               illegal
);

  dec_state_e   state_q, state_d;
  instr_body_t  prefix_q, prefix_d;

  logic [OPNUM_W-1:0] op_q, op_d;
  logic [2:0]         dest_q, dest_d;
  logic [2:0]         src_1_q, src_1_d;
  logic [2:0]         src_2_q, src_2_d;
  logic [2:0]         imm_1_q, imm_1_d;
  logic [5:0]         imm_2_q, imm_2_d;
  logic [8:0]         imm_3_q, imm_3_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;

  instr_word_t        word;
  instr_body_t        dec_body;
  logic               accept;
  logic               in_second;
  logic               starts_long;
  logic               long_illegal;
  logic [OPNUM_W-1:0] tbl_op;
  logic [2:0]         tbl_imm_1;
  logic [5:0]         tbl_imm_2;
  logic               tbl_illegal;

  assign instr_ready  = !stall;
  assign word         = instr_word_t'(instr_word);
  assign accept       = instr_valid && instr_ready && !flush;
  assign in_second    = (state_q == ST_SECOND);
  assign starts_long  = !in_second && word.long_flag && LONG_EN;
  assign long_illegal = !in_second && word.long_flag && !LONG_EN;
  // The second word only contributes immediate bits; fields come from the prefix.
  assign dec_body     = in_second ? prefix_q : word.body;

  decode_table #(
    .OPNUM_W(OPNUM_W)
  ) u_decode_table (
    .cls          (dec_body.cls),
    .opcode       (dec_body.opcode),
    .src_1        (dec_body.src_1),
    .src_2        (dec_body.src_2),
    .long_illegal (long_illegal),
    .op           (tbl_op),
    .imm_1        (tbl_imm_1),
    .imm_2        (tbl_imm_2),
    .illegal      (tbl_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FIRST;
      prefix_q  <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      src_1_q   <= '0;
      src_2_q   <= '0;
      imm_1_q   <= '0;
      imm_2_q   <= '0;
      imm_3_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prefix_q  <= prefix_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      src_1_q   <= src_1_d;
      src_2_q   <= src_2_d;
      imm_1_q   <= imm_1_d;
      imm_2_q   <= imm_2_d;
      imm_3_q   <= imm_3_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    if (flush) begin
      state_d  = ST_FIRST;
      prefix_d = '0;
    end else if (accept) begin
      case (state_q)
        ST_FIRST: begin
          if (starts_long) begin
            state_d  = ST_SECOND;
            prefix_d = word.body;
          end
        end
        ST_SECOND: begin
          state_d  = ST_FIRST;
          prefix_d = '0;
        end
        default: state_d = ST_FIRST;
      endcase
    end
  end

  always_comb begin
    op_d      = op_q;
    dest_d    = dest_q;
    src_1_d   = src_1_q;
    src_2_d   = src_2_q;
    imm_1_d   = imm_1_q;
    imm_2_d   = imm_2_q;
    imm_3_d   = imm_3_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      if (accept && !starts_long) begin
        op_d      = tbl_op;
        dest_d    = dec_body.dest;
        src_1_d   = dec_body.src_1;
        src_2_d   = dec_body.src_2;
        imm_1_d   = tbl_imm_1;
        imm_2_d   = tbl_imm_2;
        imm_3_d   = {instr_word[5:0], dec_body.src_2};
        valid_d   = 1'b1;
        illegal_d = tbl_illegal;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  assign operationnumber = op_q;
  assign destination     = dest_q;
  assign source_1        = src_1_q;
  assign source_2        = src_2_q;
  assign unsigned_1      = imm_1_q;
  assign unsigned_2      = imm_2_q;
  assign unsigned_3      = imm_3_q;
  assign decode_valid    = valid_q;
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios followed by random traffic,
// all compared against a word-level reference model.
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr_word;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic [5:0]  operationnumber;
  logic [2:0]  destination;
  logic [2:0]  source_1;
  logic [2:0]  source_2;
  logic [2:0]  unsigned_1;
  logic [5:0]  unsigned_2;
  logic [8:0]  unsigned_3;
  logic        decode_valid;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_valid, m_ill, m_pend, m_u3_known;
  int          m_op, m_dst, m_s1, m_s2, m_u1, m_u2, m_u3;
  logic [15:0] m_prefix;

  instruction_decode #(.OPNUM_W(6), .LONG_EN(1'b1)) dut (
    .clock           (clock),
    .reset           (reset),
    .instr_word      (instr_word),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .stall           (stall),
    .flush           (flush),
    .operationnumber (operationnumber),
    .destination     (destination),
    .source_1        (source_1),
    .source_2        (source_2),
    .unsigned_1      (unsigned_1),
    .unsigned_2      (unsigned_2),
    .unsigned_3      (unsigned_3),
    .decode_valid    (decode_valid),
    .illegal         (illegal)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the intended behaviour, expressed on whole words.
  task automatic model_step(input logic [15:0] w, input bit v, input bit st,
                            input bit fl, input bit rs);
    logic [15:0] b;
    int cls, opc;
    if (rs) begin
      m_valid = 0; m_ill = 0; m_pend = 0; m_prefix = '0;
      m_op = 0; m_dst = 0; m_s1 = 0; m_s2 = 0; m_u1 = 0; m_u2 = 0; m_u3 = 0;
      m_u3_known = 1;
    end else if (fl) begin
      m_valid = 0; m_ill = 0; m_pend = 0;
    end else if (st) begin
      // everything holds
    end else if (v) begin
      if (!m_pend && w[15]) begin
        m_pend = 1; m_prefix = w; m_valid = 0;
      end else begin
        b     = m_pend ? m_prefix : w;
        cls   = int'(b[14:13]);
        opc   = int'(b[12:9]);
        m_dst = int'(b[8:6]);
        m_s1  = int'(b[5:3]);
        m_s2  = int'(b[2:0]);
        m_u1  = m_s2;
        m_u2  = m_s1 * 8 + m_s2;
        m_ill = 0;
        if (cls == 0) m_op = opc;
        else if (cls == 1 && opc < 2) m_op = 16 + opc;
        else begin m_op = 0; m_ill = 1; end
        if (m_pend) begin
          m_u3 = int'(w[5:0]) * 8 + m_s2;
          m_u3_known = 1;
        end else begin
          m_u3_known = 0;
        end
        m_pend  = 0;
        m_valid = 1;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic cycle(input logic [15:0] w, input bit v, input bit st,
                       input bit fl, input bit rs);
    instr_word  = w;
    instr_valid = v;
    stall       = st;
    flush       = fl;
    reset       = rs;
    #1;
    check_eq("instr_ready", 32'(instr_ready), 32'(!st));
    @(posedge clock);
    model_step(w, v, st, fl, rs);
    #1;
    check_eq("decode_valid", 32'(decode_valid), 32'(m_valid));
    check_eq("illegal", 32'(illegal), 32'(m_ill));
    check_eq("operationnumber", 32'(operationnumber), m_op);
    check_eq("destination", 32'(destination), m_dst);
    check_eq("source_1", 32'(source_1), m_s1);
    check_eq("source_2", 32'(source_2), m_s2);
    check_eq("unsigned_1", 32'(unsigned_1), m_u1);
    check_eq("unsigned_2", 32'(unsigned_2), m_u2);
    if (m_u3_known) check_eq("unsigned_3", 32'(unsigned_3), m_u3);
  endtask

  initial begin
    m_u3_known = 0;
    // Reset for two cycles
    cycle(16'h0000, 0, 0, 0, 1);
    cycle(16'h0000, 0, 0, 0, 1);
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_valid", 32'(decode_valid), 32'd0);

    // Short add
    cycle(16'h0253, 1, 0, 0, 0);
    check_eq("add_op", 32'(operationnumber), 32'd1);
    check_eq("add_dst", 32'(destination), 32'd1);
    check_eq("add_s1", 32'(source_1), 32'd2);
    check_eq("add_s2", 32'(source_2), 32'd3);
    cycle(16'h0000, 0, 0, 0, 0);

    // Long opcode 15
    cycle(16'h9E05, 1, 0, 0, 0);
    check_eq("long_first_valid", 32'(decode_valid), 32'd0);
    cycle(16'h002A, 1, 0, 0, 0);
    check_eq("long_op", 32'(operationnumber), 32'd15);
    check_eq("long_u3", 32'(unsigned_3), 32'h155);
    check_eq("long_valid", 32'(decode_valid), 32'd1);

    // Stall with valid held high, then release
    cycle(16'h0253, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(16'h0A5C, 1, 1, 0, 0);
    check_eq("stall_held_valid", 32'(decode_valid), 32'd1);
    cycle(16'h0A5C, 1, 0, 0, 0);
    cycle(16'h0000, 0, 0, 0, 0);

    // Flush drops a pending prefix and the word in the flush cycle
    cycle(16'h8000, 1, 0, 0, 0);
    cycle(16'h0253, 1, 0, 1, 0);
    check_eq("flush_valid", 32'(decode_valid), 32'd0);
    cycle(16'h0253, 1, 0, 0, 0);
    check_eq("after_flush_op", 32'(operationnumber), 32'd1);
    check_eq("after_flush_valid", 32'(decode_valid), 32'd1);

    // Illegal class, then a legal word clears it
    cycle(16'h4400, 1, 0, 0, 0);
    check_eq("ill_flag", 32'(illegal), 32'd1);
    check_eq("ill_op", 32'(operationnumber), 32'd0);
    cycle(16'h0253, 1, 0, 0, 0);
    check_eq("ill_cleared", 32'(illegal), 32'd0);

    // Class 01 loads
    cycle(16'h2000 | 16'h0000 | 16'h01FF, 1, 0, 0, 0);
    cycle(16'h2200 | 16'h00AD, 1, 0, 0, 0);

    // Reset in the middle of a long instruction
    cycle(16'h9E05, 1, 0, 0, 0);
    cycle(16'h0000, 0, 0, 0, 1);
    cycle(16'h0253, 1, 0, 0, 0);
    check_eq("rst_mid_long_op", 32'(operationnumber), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      bit v, st, fl, rs;
      w     = 16'($urandom);
      w[15] = ($urandom_range(0, 3) == 0);
      v     = ($urandom_range(0, 9) < 7);
      st    = ($urandom_range(0, 4) == 0);
      fl    = ($urandom_range(0, 24) == 0);
      rs    = ($urandom_range(0, 199) == 0);
      cycle(w, v, st, fl, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
